imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Boot-time writer for the instruction memory. It is the write-side counterpart to the imem byte store that the IFU reads.
// - Accepts a byte stream over a valid/ready handshake, frames it as a length header plus big-endian MIPS words, and writes each byte into imem.
// - Holds the CPU in reset (cpu_hold) until the image is fully written.
// PARAMETERS
// - ADDR_WIDTH  10  imem byte-address width; capacity = 2**ADDR_WIDTH bytes = 2**(ADDR_WIDTH-2) words
// PORTS
// - clk        in   1           system clock, rising edge
// - reset_n    in   1           asynchronous active-low reset
// - in_valid   in   1           stream byte valid
// - in_data    in   8           stream byte
// - in_ready   out  1           loader accepts a byte this cycle
// - reload     in   1           single-cycle pulse; restarts loading from DONE or ERR
// - mem_we     out  1           imem byte write strobe
// - mem_addr   out  ADDR_WIDTH  imem byte address
// - mem_wdata  out  8           imem byte data
// - cpu_hold   out  1           1 = keep CPU in reset
// - done       out  1           image loaded successfully (level)
// - error      out  1           framing or size error (level)
// BEHAVIOUR
// - Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, state=LEN_HI, counters=0.
// - Handshake: a byte transfers on a rising edge with in_valid & in_ready. in_ready is combinational from state only: 1 in LEN_HI, LEN_LO, DATA (and CSUM if enabled), else 0.
// - State LEN_HI: transfer -> len[15:8] := byte, go to LEN_LO.
// - State LEN_LO: transfer -> len[7:0] := byte, then:
//   - len == 0 -> DONE;
//   - len > 2**(ADDR_WIDTH-2) -> ERR;
//   - otherwise -> DATA, with byte counter cleared.
// - State DATA: each transfer registers one imem write. mem_we=1 on the cycle after acceptance, with mem_addr = byte count and mem_wdata = byte.
//   - Bytes are taken in stream order, so word k is written at addresses 4k..4k+3 (big-endian, MSB first).
//   - After byte 4*len-1 is accepted -> DONE (or CSUM). The final write completes in the first cycle of the next state.
// - State DONE: cpu_hold=0, done=1. Stream bytes are ignored (in_ready=0).
// - State ERR: error=1, cpu_hold=1. No further writes occur; bytes already written stay in imem.
// - reload pulse in DONE/ERR -> LEN_HI, cpu_hold=1, done=0, error=0, counters cleared. reload in any other state is ignored.
// - Byte counter is ADDR_WIDTH+1 bits wide (no wrap). The maximum length fills imem exactly, with the last address = 2**ADDR_WIDTH-1.
// - Throughput: one byte per cycle when in_valid is held high. Gaps in in_valid stall with no state change.
// - Asynchronous reset mid-load aborts immediately. mem_we drops at once, and the partially written image is not cleared.
// - mem_we is never asserted outside DATA (plus the single trailing cycle after the last DATA byte).
// CONFIGURATION
// - IMEM_LOADER_CHECKSUM_EN defined:
//   - After the last DATA byte the loader enters CSUM and accepts one more byte.
//   - That byte must equal the XOR of the two length bytes and all data bytes; match -> DONE, mismatch -> ERR.
//   - For len == 0 the loader still goes to CSUM, and the expected value is XOR of the header bytes (0x00).
// - Undefined: no CSUM state; DATA -> DONE directly, and any trailing byte is ignored.
// TESTING
// - Reset release, no stream -> cpu_hold=1, in_ready=1, mem_we=0, done=0 indefinitely.
// - Stream 00 01 12 34 56 78 (no checksum) -> writes addr0..3 = 12,34,56,78 on consecutive cycles.
//   - done=1 and cpu_hold=0 one cycle after the last write completes.
// - Stream 00 02 + 8 bytes with in_valid toggled every other cycle -> 8 writes at addr 0..7, order preserved, then done=1.
// - ADDR_WIDTH=4, header 00 05 -> error=1, cpu_hold=1, zero mem_we pulses. Then reload + header 00 04 + 16 bytes -> last write at addr 15, done=1.
// - Header 00 00 -> done=1 immediately with no writes (without CHECKSUM_EN). With CHECKSUM_EN, trailing byte 00 -> done; 01 -> error.
// - With CHECKSUM_EN, stream 00 01 AA BB CC DD + byte 01^AA^BB^CC^DD=0x01 -> done.
//   - Corrupt the checksum byte -> error=1, while the data bytes are still present in imem.
// - Deassert reset_n during the 3rd DATA byte -> mem_we=0 at once. After release: state LEN_HI, cpu_hold=1, and a fresh image loads correctly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and imem write-port bundle for the instruction-memory loader.
// slave: the loader side (consumes the stream, drives the imem write port).
// master: the stream source / imem side.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Frames a byte stream as a 16-bit big-endian word count followed by
// 4*len data bytes, writes each data byte to imem at its stream offset and
// holds the CPU in reset until the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the XOR of both header bytes and all data bytes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// LEN_HI | waiting for length high byte
// LEN_LO | waiting for length low byte; decides DATA / DONE / ERR
// DATA   | writing data bytes, one imem write per accepted byte
// CSUM   | waiting for checksum byte (checksum build only)
// DONE   | image loaded, CPU released
// ERR    | length or checksum error, CPU held
module imem_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   imem_loader_if.slave bus,
   input  logic         reload,
   output logic         cpu_hold,
   output logic         done,
   output logic         error
);

   typedef enum logic [2:0] {
      LEN_HI = 3'd0,
      LEN_LO = 3'd1,
      DATA   = 3'd2,
      CSUM   = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_t;

   // Largest legal word count: the image fills imem exactly.
   localparam logic [16:0]         MAX_WORDS = 17'(1) << (ADDR_WIDTH - 2);
   localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

   state_t state;
   state_t state_nxt;

   logic [7:0]            len_hi;
   logic [ADDR_WIDTH:0]   byte_cnt;
   logic [ADDR_WIDTH:0]   last_byte;
   logic [16:0]           len_full;
   logic                  len_zero;
   logic                  len_big;
   logic [ADDR_WIDTH:0]   total_bytes;
   logic                  ready_st;
   logic                  accept;
   logic                  last_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]            csum;
`endif

   // Length decode happens on the LEN_LO transfer, so it uses the live byte.
   assign len_full    = {1'b0, len_hi, bus.in_data};
   assign len_zero    = (len_full == 17'd0);
   assign len_big     = (len_full > MAX_WORDS);
   // Only meaningful when len is in range, where it fits ADDR_WIDTH-1 bits.
   assign total_bytes = {len_full[ADDR_WIDTH-2:0], 2'b00};

   // ready is held low while reset is asserted so nothing looks acceptable.
   assign bus.in_ready = ready_st & reset_n;
   assign accept       = bus.in_valid & ready_st;
   assign last_data    = (byte_cnt == last_byte);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= LEN_HI;
      else          state <= state_nxt;
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      state_nxt = state;
      ready_st  = 1'b0;
      cpu_hold  = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      case (state)
         LEN_HI: begin
            ready_st = 1'b1;
            if (accept) state_nxt = LEN_LO;
         end
         LEN_LO: begin
            ready_st = 1'b1;
            if (accept) begin
               if (len_zero) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_nxt = CSUM;
`else
                  state_nxt = DONE;
`endif
               end else if (len_big) begin
                  state_nxt = ERR;
               end else begin
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            ready_st = 1'b1;
            if (accept && last_data) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = CSUM;
`else
               state_nxt = DONE;
`endif
            end
         end
         CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            ready_st = 1'b1;
            if (accept) state_nxt = (bus.in_data == csum) ? DONE : ERR;
`else
            state_nxt = ERR;
`endif
         end
         DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
            if (reload) state_nxt = LEN_HI;
         end
         ERR: begin
            error = 1'b1;
            if (reload) state_nxt = LEN_HI;
         end
         default: state_nxt = LEN_HI;
      endcase
   end

   // Header capture, byte counting and the registered imem write port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_hi        <= '0;
         byte_cnt      <= '0;
         last_byte     <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum          <= '0;
`endif
      end else begin
         bus.mem_we <= 1'b0;
         case (state)
            LEN_HI: begin
               if (accept) begin
                  len_hi <= bus.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum   <= bus.in_data;
`endif
               end
            end
            LEN_LO: begin
               if (accept) begin
                  byte_cnt  <= '0;
                  last_byte <= total_bytes - CNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum      <= csum ^ bus.in_data;
`endif
               end
            end
            DATA: begin
               if (accept) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= byte_cnt[ADDR_WIDTH-1:0];
                  bus.mem_wdata <= bus.in_data;
                  byte_cnt      <= byte_cnt + CNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum          <= csum ^ bus.in_data;
`endif
               end
            end
            DONE, ERR: begin
               if (reload) begin
                  len_hi    <= '0;
                  byte_cnt  <= '0;
                  last_byte <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum      <= '0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with a small (16-byte) imem.
// Expected imem writes are queued by a framing model before each stream is
// driven; a monitor pops and compares every mem_we cycle.
module tb_imem_loader;
   localparam int AW   = 4;
   localparam int MAXW = 1 << (AW - 2);

   typedef logic [7:0] b8_t;
   typedef struct {
      int addr;
      int data;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic reload = 1'b0;
   logic cpu_hold, done, error;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .reload   (reload),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   wr_t exp_q[$];
   int  wr_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the next queued expectation.
   always @(negedge clk) begin
      if (reset_n && bus.mem_we === 1'b1) begin
         wr_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%0h data=%0h expected=no write", bus.mem_addr, bus.mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), e.addr);
            chk("wr_data", 32'(bus.mem_wdata), e.data);
         end
      end
   end

   // Framing model: queues the expected writes and returns how many stream
   // bytes should be accepted and whether the image should end in done.
   task automatic model(input b8_t s[$], output int n_acc, output bit exp_done);
      int len;
      len = int'(s[0]) * 256 + int'(s[1]);
      if (len > MAXW) begin
         n_acc    = 2;
         exp_done = 1'b0;
      end else begin
         int nb;
         nb = 4 * len;
         for (int i = 0; i < nb; i++) begin
            wr_t w;
            w.addr = i;
            w.data = int'(s[2 + i]);
            exp_q.push_back(w);
         end
         n_acc = 2 + nb;
`ifdef IMEM_LOADER_CHECKSUM_EN
         begin
            b8_t x;
            x = 8'h00;
            for (int i = 0; i < 2 + nb; i++) x = x ^ s[i];
            n_acc    = n_acc + 1;
            exp_done = (s[2 + nb] == x);
         end
`else
         exp_done = 1'b1;
`endif
      end
   endtask

   task automatic drive_stream(input b8_t s[$], input int n_acc, input bit gap);
      for (int i = 0; i < s.size(); i++) begin
         if (gap && i > 0) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            reload       = 1'b0;
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = s[i];
         // reload is only legal-to-ignore while loading, never in DONE/ERR
         reload       = (i < n_acc) && ($urandom_range(0, 7) == 0);
         chk("in_ready", 32'(bus.in_ready), 32'(i < n_acc));
         @(posedge clk);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      reload       = 1'b0;
   endtask

   task automatic run_image(input string name, input b8_t s[$], input bit gap);
      int n_acc;
      bit exp_done;
      int n;
      model(s, n_acc, exp_done);
      drive_stream(s, n_acc, gap);
      n = 0;
      while (!(done === 1'b1 || error === 1'b1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk({name, "_done"}, 32'(done), 32'(exp_done));
      chk({name, "_error"}, 32'(error), 32'(!exp_done));
      chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
      chk({name, "_pending_writes"}, exp_q.size(), 0);
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk("reload_done", 32'(done), 0);
      chk("reload_error", 32'(error), 0);
      chk("reload_cpu_hold", 32'(cpu_hold), 1);
      chk("reload_in_ready", 32'(bus.in_ready), 1);
   endtask

   task automatic build(input int len, input bit corrupt, input int extra, output b8_t s[$]);
      b8_t x;
      s = {};
      s.push_back(8'(len >> 8));
      s.push_back(8'(len));
      x = s[0] ^ s[1];
      if (len <= MAXW) begin
         for (int i = 0; i < 4 * len; i++) begin
            b8_t d;
            d = 8'($urandom);
            s.push_back(d);
            x = x ^ d;
         end
         s.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
      end
      for (int i = 0; i < extra; i++) s.push_back(8'($urandom));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      b8_t s[$];
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // reset asserted
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_cpu_hold", 32'(cpu_hold), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
      reset_n = 1'b1;

      // idle after release
      for (int i = 0; i < 4; i++) begin
         repeat (5) @(negedge clk);
         chk("idle_cpu_hold", 32'(cpu_hold), 1);
         chk("idle_in_ready", 32'(bus.in_ready), 1);
         chk("idle_mem_we", 32'(bus.mem_we), 0);
         chk("idle_done", 32'(done), 0);
      end

      // single word, back-to-back writes (last byte is the checksum if enabled)
      wr_cyc_q = {};
      s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      run_image("one_word", s, 1'b0);
      chk("one_word_nwrites", wr_cyc_q.size(), 4);
      if (wr_cyc_q.size() == 4) chk("one_word_span", wr_cyc_q[3] - wr_cyc_q[0], 3);
      do_reload();

      // two words with in_valid toggling
      build(2, 1'b0, 0, s);
      run_image("gapped", s, 1'b1);
      do_reload();

      // too long for a 16-byte imem, then a maximum-size image
      s = '{8'h00, 8'h05, 8'h11, 8'h22, 8'h33};
      run_image("too_long", s, 1'b0);
      do_reload();
      s = '{8'h01, 8'h00, 8'h00};
      run_image("len_256", s, 1'b0);
      do_reload();
      wr_cyc_q = {};
      build(4, 1'b0, 1, s);
      run_image("max_len", s, 1'b0);
      chk("max_len_nwrites", wr_cyc_q.size(), 16);
      do_reload();

      // zero-length images
      s = '{8'h00, 8'h00, 8'h00};
      run_image("len0_ok", s, 1'b0);
      do_reload();
      s = '{8'h00, 8'h00, 8'h01};
      run_image("len0_b01", s, 1'b0);
      do_reload();

      // checksum match and corruption
      s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
      run_image("csum_good", s, 1'b0);
      do_reload();
      s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h5A};
      run_image("csum_bad", s, 1'b0);
      do_reload();

      // asynchronous reset during the third data byte
      s = '{8'h00, 8'h02, 8'hA0, 8'hA1, 8'hA2};
      begin
         wr_t w;
         w.addr = 0; w.data = 'hA0; exp_q.push_back(w);
         w.addr = 1; w.data = 'hA1; exp_q.push_back(w);
      end
      for (int i = 0; i < s.size(); i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = s[i];
         @(posedge clk);
      end
      #1;
      chk("abort_we_before", 32'(bus.mem_we), 1);
      reset_n = 1'b0;
      #1;
      chk("abort_we_drop", 32'(bus.mem_we), 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", 32'(bus.in_ready), 1);
      chk("abort_cpu_hold", 32'(cpu_hold), 1);
      chk("abort_done", 32'(done), 0);
      chk("abort_error", 32'(error), 0);
      chk("abort_pending", exp_q.size(), 0);
      build(3, 1'b0, 0, s);
      run_image("after_abort", s, 1'b0);
      do_reload();

      // randomized images
      for (int n = 0; n < 25; n++) begin
         int len;
         int r;
         r = $urandom_range(0, 9);
         len = (r == 9) ? $urandom_range(256, 1024) : $urandom_range(0, MAXW + 1);
         build(len, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), s);
         run_image("rand", s, 1'($urandom_range(0, 1)));
         do_reload();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
